// File: rtl/cntr_arb_pkg.sv
// cntr_arb_pkg: shared types, constants and the round-robin pick helper for
// the run-counter arbiter.
//   state_t      - run sequencer states (IDLE, RUN, DONE)
//   MAX_CNT_DEF  - default hard ceiling on the counter value
//   rr_pick()    - first requesting index scanning from ptr+1 around to ptr
package cntr_arb_pkg;

  typedef enum logic [1:0] {
    IDLE,
    RUN,
    DONE
  } state_t;

  localparam int unsigned MAX_CNT_DEF = 3;

  // Widest requester vector the helper handles; narrower users zero-extend.
  localparam int unsigned RR_MAXREQ = 8;

  typedef struct packed {
    logic       valid;
    logic [2:0] idx;
  } rr_pick_t;

  // nreq is a constant at every call site, so the modulo folds away.
  function automatic rr_pick_t rr_pick(input logic [RR_MAXREQ-1:0] req,
                                       input logic [2:0]           ptr,
                                       input int unsigned          nreq);
    rr_pick_t    r;
    int unsigned idx;
    r   = '0;
    idx = 0;
    for (int unsigned i = 1; i <= RR_MAXREQ; i++) begin
      idx = (32'(ptr) + i) % nreq;
      if (i <= nreq && !r.valid && req[idx[2:0]]) begin
        r.valid = 1'b1;
        r.idx   = idx[2:0];
      end
    end
    return r;
  endfunction

endpackage

// File: rtl/cntr_rr_arb.sv
// cntr_rr_arb: combinational round-robin picker.
//   req    - request vector, one bit per requester
//   ptr    - index of the last winner; the scan starts just after it
//   winner - index of the chosen requester (valid only when valid=1)
//   valid  - at least one request is present
module cntr_rr_arb
  import cntr_arb_pkg::*;
#(
  parameter int unsigned NREQ = 4
) (
  input  logic [NREQ-1:0]         req,
  input  logic [$clog2(NREQ)-1:0] ptr,
  output logic [$clog2(NREQ)-1:0] winner,
  output logic                    valid
);

  localparam int unsigned IW = $clog2(NREQ);

  rr_pick_t pick;

  always_comb begin
    pick   = rr_pick(RR_MAXREQ'(req), 3'(ptr), NREQ);
    winner = IW'(pick.idx);
    valid  = pick.valid;
  end

endmodule

// File: rtl/cntr_run_arbiter.sv
// cntr_run_arbiter: grants one shared bounded run-counter to NREQ requesters
// in round-robin order and sequences each run (clear, count to limit, done).
//   clk       - system clock
//   reset_n   - asynchronous active-low reset
//   req       - level request per requester, held until done or abort
//   limit     - per-requester target count, slice i = limit[i*CW +: CW]
//   gnt       - one-hot grant, zero when no run is active
//   busy      - high while a run is in progress
//   cntr      - current counter value, never above MAX_CNT
//   done      - one-cycle pulse on normal run completion
//   done_id   - requester index of the completed run, valid with done
//   err_clamp - one-cycle pulse when a granted limit was clamped to MAX_CNT
module cntr_run_arbiter
  import cntr_arb_pkg::*;
#(
  parameter int unsigned NREQ    = 4,
  parameter int unsigned CW      = 4,
  parameter int unsigned MAX_CNT = MAX_CNT_DEF
) (
  input  logic                    clk,
  input  logic                    reset_n,
  input  logic [NREQ-1:0]         req,
  input  logic [NREQ*CW-1:0]      limit,
  output logic [NREQ-1:0]         gnt,
  output logic                    busy,
  output logic [CW-1:0]           cntr,
  output logic                    done,
  output logic [$clog2(NREQ)-1:0] done_id,
  output logic                    err_clamp
);

  localparam int unsigned    IW   = $clog2(NREQ);
  localparam logic [CW-1:0]  MAXV = CW'(MAX_CNT);

  state_t          state_q, state_n;
  logic [IW-1:0]   ptr_q, ptr_n, id_q, id_n, win, ptr_eff, done_id_n;
  logic            fresh_q, fresh_n, win_vld;
  logic [CW-1:0]   lim_q, lim_n, cntr_n, lim_win;
  logic [NREQ-1:0] gnt_n;
  logic            busy_n, done_n, err_n;
  logic [CW-1:0]   lim_arr [NREQ];

  always_comb begin
    for (int unsigned i = 0; i < NREQ; i++) lim_arr[i] = limit[i*CW +: CW];
  end

  // Right after reset the scan must start at index 0, so present the picker
  // with NREQ-1 as the last winner until the first grant is made.
  assign ptr_eff = fresh_q ? IW'(NREQ - 1) : ptr_q;

  cntr_rr_arb #(.NREQ(NREQ)) u_arb (
    .req    (req),
    .ptr    (ptr_eff),
    .winner (win),
    .valid  (win_vld)
  );

  assign lim_win = lim_arr[win];

  always_comb begin
    state_n   = state_q;
    ptr_n     = ptr_q;
    fresh_n   = fresh_q;
    id_n      = id_q;
    lim_n     = lim_q;
    cntr_n    = cntr;
    gnt_n     = gnt;
    busy_n    = busy;
    done_n    = 1'b0;
    done_id_n = '0;
    err_n     = 1'b0;
    case (state_q)
      IDLE: begin
        gnt_n  = '0;
        busy_n = 1'b0;
        cntr_n = '0;
        if (win_vld) begin
          state_n = RUN;
          id_n    = win;
          lim_n   = (lim_win > MAXV) ? MAXV : lim_win;
          err_n   = (lim_win > MAXV);
          gnt_n   = NREQ'(1) << win;
          busy_n  = 1'b1;
          ptr_n   = win;
          fresh_n = 1'b0;
        end
      end
      RUN: begin
        // Abort wins over completion when both happen on the same edge.
        if (!req[id_q]) begin
          state_n = IDLE;
          gnt_n   = '0;
          busy_n  = 1'b0;
          cntr_n  = '0;
        end else if (cntr == lim_q) begin
          state_n   = DONE;
          gnt_n     = '0;
          busy_n    = 1'b0;
          done_n    = 1'b1;
          done_id_n = id_q;
        end else begin
          cntr_n = cntr + CW'(1);
        end
      end
      DONE: begin
        state_n = IDLE;
        cntr_n  = '0;
      end
      default: state_n = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q   <= IDLE;
      ptr_q     <= '0;
      fresh_q   <= 1'b1;
      id_q      <= '0;
      lim_q     <= '0;
      cntr      <= '0;
      gnt       <= '0;
      busy      <= 1'b0;
      done      <= 1'b0;
      done_id   <= '0;
      err_clamp <= 1'b0;
    end else begin
      state_q   <= state_n;
      ptr_q     <= ptr_n;
      fresh_q   <= fresh_n;
      id_q      <= id_n;
      lim_q     <= lim_n;
      cntr      <= cntr_n;
      gnt       <= gnt_n;
      busy      <= busy_n;
      done      <= done_n;
      done_id   <= done_id_n;
      err_clamp <= err_n;
    end
  end

endmodule

// File: tb/tb_cntr_run_arbiter.sv
// tb_cntr_run_arbiter: directed bench for cntr_run_arbiter with a scoreboard
// of expected grant/done events and per-cycle invariant checks.
module tb_cntr_run_arbiter;

  logic        clk = 1'b0;
  logic        reset_n;
  logic [3:0]  req;
  logic [15:0] limit;
  logic [3:0]  gnt;
  logic        busy;
  logic [3:0]  cntr;
  logic        done;
  logic [1:0]  done_id;
  logic        err_clamp;

  int vectors = 0;
  int fails   = 0;

  typedef struct {
    bit is_done;
    int id;
    int clamp;
    int cnt;
  } ev_t;

  ev_t sb[$];

  always #5 clk = ~clk;

  cntr_run_arbiter #(.NREQ(4), .CW(4), .MAX_CNT(3)) dut (
    .clk       (clk),
    .reset_n   (reset_n),
    .req       (req),
    .limit     (limit),
    .gnt       (gnt),
    .busy      (busy),
    .cntr      (cntr),
    .done      (done),
    .done_id   (done_id),
    .err_clamp (err_clamp)
  );

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    vectors++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic push_grant(input int id, input int clamp);
    ev_t e;
    e.is_done = 1'b0; e.id = id; e.clamp = clamp; e.cnt = 0;
    sb.push_back(e);
  endtask

  task automatic push_done(input int id, input int cnt);
    ev_t e;
    e.is_done = 1'b1; e.id = id; e.clamp = 0; e.cnt = cnt;
    sb.push_back(e);
  endtask

  task automatic check_event(input bit is_done);
    ev_t e;
    chk("sb_nonempty", 32'(sb.size() != 0), 1);
    if (sb.size() != 0) begin
      e = sb.pop_front();
      chk("sb_kind", 32'(is_done), 32'(e.is_done));
      if (!is_done) begin
        chk("sb_gnt", 32'(gnt), 32'(1) << e.id);
        chk("sb_err_clamp", 32'(err_clamp), 32'(e.clamp));
      end else begin
        chk("sb_done_id", 32'(done_id), 32'(e.id));
        chk("sb_done_cntr", 32'(cntr), 32'(e.cnt));
      end
    end
  endtask

  logic [3:0] prev_gnt = '0;

  always @(negedge clk) begin
    if (reset_n === 1'b1) begin
      chk("inv_cntr_max", 32'(cntr <= 4'd3), 1);
      chk("inv_gnt_onehot0", 32'($onehot0(gnt)), 1);
      chk("inv_busy_gnt", 32'(busy), 32'(|gnt));
      chk("inv_done_busy", 32'(done & busy), 0);
      chk("inv_done_gnt", 32'(done && (gnt != 0)), 0);
      if (gnt != 0 && prev_gnt == 0) check_event(1'b0);
      if (done) check_event(1'b1);
    end
    prev_gnt = gnt;
  end

  initial begin
    // Reset then idle
    reset_n = 1'b0;
    req     = '0;
    limit   = '0;
    repeat (5) @(negedge clk);
    chk("rst_gnt", 32'(gnt), 0);
    chk("rst_busy", 32'(busy), 0);
    chk("rst_cntr", 32'(cntr), 0);
    chk("rst_done", 32'(done), 0);
    chk("rst_done_id", 32'(done_id), 0);
    chk("rst_err_clamp", 32'(err_clamp), 0);
    reset_n = 1'b1;
    for (int i = 0; i < 10; i++) begin
      @(negedge clk);
      chk("idle_gnt", 32'(gnt), 0);
    end

    // Single run, requester 2, limit 3
    push_grant(2, 0);
    push_done(2, 3);
    limit[2*4 +: 4] = 4'd3;
    req = 4'b0100;
    for (int k = 0; k < 4; k++) begin
      @(negedge clk);
      chk("run_gnt", 32'(gnt), 32'h4);
      chk("run_cntr", 32'(cntr), 32'(k));
    end
    @(negedge clk);
    chk("run_done", 32'(done), 1);
    chk("run_done_id", 32'(done_id), 2);
    chk("run_done_gnt", 32'(gnt), 0);
    req = '0;
    @(negedge clk);
    chk("run_after_done", 32'(done), 0);
    chk("run_after_cntr", 32'(cntr), 0);

    // Clamp, requester 1, limit 9
    push_grant(1, 1);
    push_done(1, 3);
    limit[1*4 +: 4] = 4'd9;
    req = 4'b0010;
    for (int k = 0; k < 4; k++) begin
      @(negedge clk);
      chk("clamp_gnt", 32'(gnt), 32'h2);
      chk("clamp_cntr", 32'(cntr), 32'(k));
      chk("clamp_err", 32'(err_clamp), 32'(k == 0));
    end
    @(negedge clk);
    chk("clamp_done", 32'(done), 1);
    chk("clamp_done_id", 32'(done_id), 1);
    chk("clamp_done_cntr", 32'(cntr), 3);
    req = '0;
    @(negedge clk);

    // Round robin from a fresh reset, all limits 0
    reset_n = 1'b0;
    repeat (2) @(negedge clk);
    reset_n = 1'b1;
    limit = '0;
    for (int g = 0; g < 5; g++) begin
      push_grant(g % 4, 0);
      push_done(g % 4, 0);
    end
    req = 4'b1111;
    for (int t = 0; t < 14; t++) begin
      @(negedge clk);
      chk("rr_gnt", 32'(gnt), (t % 3 == 0) ? (32'(1) << ((t / 3) % 4)) : 32'(0));
      chk("rr_done", 32'(done), 32'(t % 3 == 1));
      if (t % 3 == 1) chk("rr_done_id", 32'(done_id), 32'((t / 3) % 4));
      if (t == 13) req = '0;
    end
    @(negedge clk);
    chk("rr_end_gnt", 32'(gnt), 0);

    // Abort requester 0 at cntr=1; pending requester 3 follows
    limit[0*4 +: 4] = 4'd3;
    limit[3*4 +: 4] = 4'd3;
    push_grant(0, 0);
    push_grant(3, 0);
    req = 4'b0001;
    @(negedge clk);
    chk("abort_gnt", 32'(gnt), 32'h1);
    chk("abort_cntr0", 32'(cntr), 0);
    req = 4'b1001;
    @(negedge clk);
    chk("abort_cntr1", 32'(cntr), 1);
    req = 4'b1000;
    @(negedge clk);
    chk("abort_gnt_off", 32'(gnt), 0);
    chk("abort_cntr_clr", 32'(cntr), 0);
    chk("abort_busy", 32'(busy), 0);
    chk("abort_no_done", 32'(done), 0);
    @(negedge clk);
    chk("abort_next_gnt", 32'(gnt), 32'h8);
    chk("abort_next_cntr", 32'(cntr), 0);
    req = '0;
    @(negedge clk);
    chk("abort2_gnt_off", 32'(gnt), 0);

    // Reset asserted mid-run
    push_grant(0, 0);
    req = 4'b0001;
    @(negedge clk);
    @(negedge clk);
    @(negedge clk);
    chk("mid_cntr2", 32'(cntr), 2);
    reset_n = 1'b0;
    #1;
    chk("mid_rst_gnt", 32'(gnt), 0);
    chk("mid_rst_cntr", 32'(cntr), 0);
    chk("mid_rst_busy", 32'(busy), 0);
    chk("mid_rst_done", 32'(done), 0);
    @(negedge clk);
    @(negedge clk);
    chk("mid_hold_done", 32'(done), 0);
    push_grant(0, 0);
    req = 4'b1001;
    reset_n = 1'b1;
    @(negedge clk);
    chk("mid_regrant", 32'(gnt), 32'h1);
    chk("mid_regrant_cntr", 32'(cntr), 0);
    req = '0;
    @(negedge clk);
    chk("mid_final_gnt", 32'(gnt), 0);
    repeat (3) @(negedge clk);
    chk("sb_drained", 32'(sb.size()), 0);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, fails);
    $finish;
  end

endmodule

// File: doc/cntr_run_arbiter.md
Name: cntr_run_arbiter

Overview:
Shares one bounded run-counter among NREQ requesters. Each requester asks for a counting run with its own limit. A round-robin arbiter grants one requester at a time, and an FSM sequences the run: clear, count to limit, signal done. The block sits in front of the counter datapath and guarantees the counter never exceeds MAX_CNT, so the "cntr <= 3" property always holds.

Parameters:
NREQ, 4, number of requesters (2..8)
CW, 4, counter and limit width in bits
MAX_CNT, 3, hard ceiling on the counter value; requested limits are clamped to it

Ports:
clk  in  1  system clock; all state changes on posedge
reset_n  in  1  asynchronous active-low reset
req  in  NREQ  level request per requester; held until done or abort
limit  in  NREQ*CW  per-requester target count; slice i = limit[i*CW +: CW]
gnt  out  NREQ  one-hot grant; zero when no run is active
busy  out  1  high while a run is in progress (RUN state)
cntr  out  CW  current counter value
done  out  1  one-cycle pulse when a run completes normally
done_id  out  $clog2(NREQ)  index of the requester whose run completed; valid while done=1
err_clamp  out  1  one-cycle pulse when a granted limit exceeded MAX_CNT and was clamped

Behaviour:
- Reset (async assert, sync release):
  - state=IDLE; gnt=0, busy=0, cntr=0, done=0, done_id=0, err_clamp=0.
  - Round-robin pointer = 0, so requester 0 has top priority.
- FSM states: IDLE, RUN, DONE. All outputs are registered.
- IDLE, if any req bit is high:
  - Winner = first requester with req high, scanning from ptr+1 mod NREQ around to ptr. Right after reset the scan starts at index 0.
  - On that edge: id_q=winner, lim_q=min(limit[winner], MAX_CNT), cntr=0, gnt=onehot(winner), busy=1, state=RUN.
  - err_clamp=1 for exactly this cycle if limit[winner] > MAX_CNT.
  - ptr=winner.
- IDLE, no req: hold; all outputs at rest values.
- RUN, normal progress:
  - If req[id_q]=1 and cntr==lim_q: state=DONE, gnt=0, busy=0, done=1, done_id=id_q, cntr holds.
  - Otherwise, if req[id_q]=1: cntr=cntr+1.
  - A run with limit L keeps gnt/busy high for L+1 cycles, with cntr showing 0..L. With L=0 it is one cycle at cntr=0.
- RUN, abort:
  - If req[id_q]=0 at a RUN edge: state=IDLE, gnt=0, busy=0, cntr=0, no done pulse.
  - Abort takes precedence over completion in the same cycle.
- DONE: done high for this single cycle; on the next edge done=0 and state=IDLE. cntr is cleared to 0 on the DONE->IDLE edge.
- Requests from non-granted requesters during RUN/DONE are ignored and not queued; they are re-evaluated in IDLE.
- Minimum spacing between back-to-back grants is 2 cycles (the DONE cycle plus the IDLE arbitration cycle).
- A changing limit[id_q] during RUN has no effect, because lim_q is latched at grant.
- Invariants for the verification engineer to assert:
  - cntr <= MAX_CNT at all times.
  - gnt is one-hot or zero.
  - busy == |gnt.
  - done and busy are never high together.
  - done implies gnt==0.
- Reset asserted mid-run: everything returns immediately to reset values, and no done pulse is generated.

Decomposition:
- Package cntr_arb_pkg holds:
  - the state enum (IDLE, RUN, DONE);
  - the MAX_CNT default constant;
  - a function rr_pick(req, ptr) returning the winner index and a valid bit.
- One sub-module, cntr_rr_arb: combinational round-robin picker taking req and ptr and returning winner and valid.
- The FSM, counter and pointer registers stay in the top level.

Test Plan:
- Reset then idle: reset_n=0 for 5 cycles, req=0 -> all outputs 0; no gnt for 10 cycles after release.
- Single run: req[2]=1, limit[2]=3 -> gnt=4'b0100 for 4 cycles with cntr 0,1,2,3; done=1 and done_id=2 for 1 cycle; then idle.
- Clamp: req[1]=1, limit[1]=9 -> err_clamp pulse at grant; cntr stops at 3 (0..3); done_id=1; cntr never exceeds 3.
- Round robin: req=4'b1111 held continuously, all limits=0 -> grant order 0,1,2,3,0 with 2 idle cycles between grants.
- Abort: req[0]=1, limit=3; drop req[0] when cntr=1 -> gnt=0 and cntr=0 next cycle, no done; pending req[3] granted on the following IDLE edge.
- Reset mid-run: assert reset_n=0 while cntr=2 -> outputs 0 asynchronously, no done; after release, requester 0 wins when req=4'b1001.
